// File: rtl/msg_stream_player_if.sv
// ----------------------------------------------------------------------------
// msg_stream_player_if
//   Character stream handshake between msg_stream_player and its consumer.
//
//   Signals:
//     out_data  [DATA_W] current character. It is 0 whenever out_valid is 0.
//     out_valid          a character is being presented.
//     out_ready          the consumer accepts the character.
//                        A transfer happens on out_valid & out_ready.
//
//   Modports:
//     master  the player side. It drives out_data and out_valid.
//     slave   the consumer side. It drives out_ready.
// ----------------------------------------------------------------------------
interface msg_stream_player_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/msg_stream_player.sv
// ----------------------------------------------------------------------------
// msg_stream_player
//   Plays a ROM-held message one character at a time.
//   A pacing divider sets the rate, and each character leaves through a
//   valid/ready handshake.
//   Playback can be one-shot or looping. The player also supports pause (en),
//   abort, a done pulse and a live ROM index.
//
//   Ports:
//     clk        clock
//     rst_n      synchronous active-low reset
//     en         pause control; 0 freezes the pacing counter
//     start      begin playback from index 0 (honoured only in IDLE with en=1)
//     abort      synchronous return to IDLE (checksum holds)
//     loop_mode  1 = restart after the last character, 0 = one-shot
//     div        pacing; each PACE phase lasts div+1 enabled cycles
//     out_if     character stream (master modport)
//     busy       high in PACE or PRESENT
//     done       one-cycle pulse at one-shot completion
//     index      ROM index of the character being paced or presented
//     checksum   modular sum of accepted characters (see MSG_CHECKSUM_EN)
//
//   Build option:
//     MSG_CHECKSUM_EN  When defined, checksum is the low DATA_W bits of the sum
//                      of characters accepted since the last start, cleared on
//                      each loop wrap. When undefined, checksum is tied to 0
//                      and no adder exists.
//
//   ROM contents:
//     The ROM holds the built-in 51-byte string. This RTL does not read files.
//     A non-empty MSG_FILE marks the image as preloaded by the implementation
//     flow, and this model then reads zeros.
// ----------------------------------------------------------------------------
module msg_stream_player #(
    parameter int    DATA_W   = 8,
    parameter int    MSG_LEN  = 51,
    parameter int    IDX_W    = 8,
    parameter int    DIV_W    = 16,
    parameter string MSG_FILE = ""
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    loop_mode,
    input  logic [DIV_W-1:0]        div,
    msg_stream_player_if.master     out_if,
    output logic                    busy,
    output logic                    done,
    output logic [IDX_W-1:0]        index,
    output logic [DATA_W-1:0]       checksum
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PACE    = 2'd1,
        S_PRESENT = 2'd2
    } state_t;

    localparam int                   BUILTIN_LEN = 51;
    localparam logic [8*BUILTIN_LEN-1:0] BUILTIN_MSG =
        "Tajumulco Tacana Acatenango Fuego Santa Maria Agua ";
    localparam bit                   USE_BUILTIN = (MSG_FILE == "");
    localparam logic [IDX_W-1:0]     LAST_IDX    = IDX_W'(MSG_LEN - 1);

    // The string literal packs its first character into the most significant
    // byte, so character i sits at byte (LEN-1-i).
    function automatic logic [DATA_W-1:0] rom_char(input logic [IDX_W-1:0] idx);
        logic [7:0] b;
        int         i;
        b = 8'h00;
        i = int'(idx);
        if (USE_BUILTIN && (i < BUILTIN_LEN)) begin
            b = BUILTIN_MSG[8*(BUILTIN_LEN-1-i) +: 8];
        end
        return DATA_W'(b);
    endfunction

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;

    logic               start_go;
    logic               hs;
    logic               is_last;

    // abort outranks both a start request and a handshake in the same cycle.
    assign start_go = (state_q == S_IDLE) && start && en && !abort;
    assign hs       = (state_q == S_PRESENT) && valid_q && out_if.out_ready && !abort;
    assign is_last  = (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        done_d  = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            data_d  = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_go) begin
                        state_d = S_PACE;
                        idx_d   = '0;
                        cnt_d   = div;
                    end
                end
                S_PACE: begin
                    if (en) begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - DIV_W'(1);
                        end else begin
                            state_d = S_PRESENT;
                            data_d  = rom_char(idx_q);
                            valid_d = 1'b1;
                        end
                    end
                end
                S_PRESENT: begin
                    // The character stays presented regardless of en until
                    // the consumer takes it.
                    if (hs) begin
                        valid_d = 1'b0;
                        data_d  = '0;
                        if (!is_last) begin
                            idx_d   = idx_q + IDX_W'(1);
                            cnt_d   = div;
                            state_d = S_PACE;
                        end else if (loop_mode) begin
                            idx_d   = '0;
                            cnt_d   = div;
                            state_d = S_PACE;
                        end else begin
                            idx_d   = '0;
                            cnt_d   = '0;
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

`ifdef MSG_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
    logic              wrap;

    // The loop-wrap handshake restarts the sum for the new pass.
    assign wrap = hs && is_last && loop_mode;

    always_comb begin
        csum_d = csum_q;
        if (start_go || wrap) begin
            csum_d = '0;
        end else if (hs) begin
            csum_d = csum_q + data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

    assign out_if.out_data  = data_q;
    assign out_if.out_valid = valid_q;
    assign busy             = (state_q != S_IDLE);
    assign done             = done_q;
    assign index            = idx_q;

endmodule

// File: tb/tb_msg_stream_player.sv
// ----------------------------------------------------------------------------
// tb_msg_stream_player
//   Directed testbench for msg_stream_player. It runs a per-cycle vector table
//   and then hand-written sequences for one-shot, backpressure, loop, pause,
//   abort and reset.
// ----------------------------------------------------------------------------
module tb_msg_stream_player;
    localparam int DATA_W  = 8;
    localparam int MSG_LEN = 51;
    localparam int IDX_W   = 8;
    localparam int DIV_W   = 16;

`ifdef MSG_CHECKSUM_EN
    localparam logic [7:0] EXP_SUM = 8'h22;
    localparam bit         CS_ON   = 1'b1;
`else
    localparam logic [7:0] EXP_SUM = 8'h00;
    localparam bit         CS_ON   = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              en;
    logic              start;
    logic              abort;
    logic              loop_mode;
    logic [DIV_W-1:0]  div;
    logic              busy;
    logic              done;
    logic [IDX_W-1:0]  index;
    logic [DATA_W-1:0] checksum;

    msg_stream_player_if #(.DATA_W(DATA_W)) sif ();

    msg_stream_player #(
        .DATA_W  (DATA_W),
        .MSG_LEN (MSG_LEN),
        .IDX_W   (IDX_W),
        .DIV_W   (DIV_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .start     (start),
        .abort     (abort),
        .loop_mode (loop_mode),
        .div       (div),
        .out_if    (sif),
        .busy      (busy),
        .done      (done),
        .index     (index),
        .checksum  (checksum)
    );

    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc   = 0;
    string msg_s = "Tajumulco Tacana Acatenango Fuego Santa Maria Agua ";

    typedef struct {
        logic        start;
        logic        en;
        logic        abort;
        logic        ready;
        logic [15:0] div;
        logic        e_valid;
        logic [7:0]  e_data;
        logic        e_busy;
        logic        e_done;
        logic [7:0]  e_idx;
    } vec_t;

    vec_t vt[18];

    function automatic vec_t mk(input int st, input int e, input int ab, input int rd,
                                input int dv, input int ev, input int ed, input int eb,
                                input int edn, input int ei);
        vec_t v;
        v.start   = 1'(st);
        v.en      = 1'(e);
        v.abort   = 1'(ab);
        v.ready   = 1'(rd);
        v.div     = 16'(dv);
        v.e_valid = 1'(ev);
        v.e_data  = 8'(ed);
        v.e_busy  = 1'(eb);
        v.e_done  = 1'(edn);
        v.e_idx   = 8'(ei);
        return v;
    endfunction

    function automatic logic [7:0] ch(input int i);
        return 8'(msg_s.getc(i));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset;
        rst_n         = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        tick();
        tick();
        rst_n         = 1'b1;
    endtask

    // Ticks until the given index is presented. Gives up after budget cycles.
    task automatic wait_valid_idx(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (sif.out_valid && (int'(index) == target)) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic start_pulse;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   ok;
        int   n_chars;
        int   last_v;
        int   done_cnt;
        int   done_cyc;
        int   v0;
        bit   seen;
        logic [7:0] exp_cs;

        en            = 1'b1;
        loop_mode     = 1'b0;
        div           = '0;
        sif.out_ready = 1'b0;
        do_reset();

        // Reset state
        chk("rst_valid", 32'(sif.out_valid), 32'd0);
        chk("rst_data", 32'(sif.out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_index", 32'(index), 32'd0);
        chk("rst_checksum", 32'(checksum), 32'd0);

        // Per-cycle vectors. Each row is applied, then one edge is taken, then
        // the outputs are compared.
        //             st en ab rd dv  ev  data   bsy dn idx
        vt[0]  = mk(1, 1, 0, 0, 0, 0, 8'h00, 1, 0, 0);
        vt[1]  = mk(0, 1, 0, 0, 0, 1, 8'h54, 1, 0, 0);
        vt[2]  = mk(0, 1, 0, 1, 0, 0, 8'h00, 1, 0, 1);
        vt[3]  = mk(0, 1, 0, 1, 0, 1, 8'h61, 1, 0, 1);
        vt[4]  = mk(0, 1, 0, 0, 0, 1, 8'h61, 1, 0, 1);
        vt[5]  = mk(0, 1, 0, 0, 0, 1, 8'h61, 1, 0, 1);
        vt[6]  = mk(0, 1, 0, 1, 0, 0, 8'h00, 1, 0, 2);
        vt[7]  = mk(0, 1, 0, 0, 0, 1, 8'h6A, 1, 0, 2);
        vt[8]  = mk(0, 1, 1, 1, 0, 0, 8'h00, 0, 0, 0);
        vt[9]  = mk(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        vt[10] = mk(1, 1, 0, 0, 2, 0, 8'h00, 1, 0, 0);
        vt[11] = mk(0, 0, 0, 0, 2, 0, 8'h00, 1, 0, 0);
        vt[12] = mk(0, 1, 0, 0, 2, 0, 8'h00, 1, 0, 0);
        vt[13] = mk(0, 1, 0, 0, 2, 0, 8'h00, 1, 0, 0);
        vt[14] = mk(0, 1, 0, 0, 2, 1, 8'h54, 1, 0, 0);
        vt[15] = mk(0, 0, 0, 0, 2, 1, 8'h54, 1, 0, 0);
        vt[16] = mk(0, 0, 0, 1, 2, 0, 8'h00, 1, 0, 1);
        vt[17] = mk(0, 1, 1, 0, 2, 0, 8'h00, 0, 0, 0);

        for (int i = 0; i < 18; i++) begin
            start         = vt[i].start;
            en            = vt[i].en;
            abort         = vt[i].abort;
            sif.out_ready = vt[i].ready;
            div           = vt[i].div;
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(sif.out_valid), 32'(vt[i].e_valid));
            chk($sformatf("vec%0d_data", i), 32'(sif.out_data), 32'(vt[i].e_data));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].e_busy));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(vt[i].e_done));
            chk($sformatf("vec%0d_index", i), 32'(index), 32'(vt[i].e_idx));
        end
        start = 1'b0;
        abort = 1'b0;
        en    = 1'b1;

        // Full one-shot pass with div=0 and the consumer always ready
        do_reset();
        div = '0; loop_mode = 1'b0; sif.out_ready = 1'b1;
        start_pulse();
        n_chars = 0; last_v = -1; done_cnt = 0; done_cyc = -1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (sif.out_valid) begin
                chk($sformatf("oneshot_char%0d", n_chars), 32'(sif.out_data), 32'(ch(n_chars)));
                chk($sformatf("oneshot_idx%0d", n_chars), 32'(index), 32'(n_chars));
                if (n_chars > 0) chk("oneshot_period", 32'(cyc - last_v), 32'd2);
                last_v = cyc;
                n_chars++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        chk("oneshot_count", 32'(n_chars), 32'd51);
        chk("oneshot_done_count", 32'(done_cnt), 32'd1);
        chk("oneshot_done_time", 32'(done_cyc), 32'(last_v + 1));
        chk("oneshot_busy_after", 32'(busy), 32'd0);
        chk("oneshot_checksum", 32'(checksum), 32'(EXP_SUM));

        // Backpressure at index 2
        do_reset();
        div = '0; sif.out_ready = 1'b1;
        start_pulse();
        wait_valid_idx(2, 20, ok);
        chk("bp_reach_idx2", 32'(ok), 32'd1);
        sif.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold_valid", 32'(sif.out_valid), 32'd1);
            chk("bp_hold_data", 32'(sif.out_data), 32'h6A);
            chk("bp_hold_idx", 32'(index), 32'd2);
        end
        sif.out_ready = 1'b1;
        tick();
        chk("bp_release_gap", 32'(sif.out_valid), 32'd0);
        tick();
        chk("bp_next_valid", 32'(sif.out_valid), 32'd1);
        chk("bp_next_data", 32'(sif.out_data), 32'h75);
        chk("bp_next_idx", 32'(index), 32'd3);
        abort = 1'b1; tick(); abort = 1'b0;

        // Loop mode with div=3 and the wrap from index 50 to index 0
        do_reset();
        div = 16'd3; loop_mode = 1'b1; sif.out_ready = 1'b1;
        start_pulse();
        wait_valid_idx(50, 400, ok);
        chk("loop_reach_idx50", 32'(ok), 32'd1);
        chk("loop_last_char", 32'(sif.out_data), 32'h20);
        v0 = cyc; seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) seen = 1'b1;
            if (sif.out_valid) break;
        end
        chk("loop_wrap_char", 32'(sif.out_data), 32'h54);
        chk("loop_wrap_idx", 32'(index), 32'd0);
        chk("loop_wrap_period", 32'(cyc - v0), 32'd5);
        chk("loop_no_done", 32'(seen), 32'd0);
        chk("loop_wrap_checksum", 32'(checksum), 32'd0);
        chk("loop_busy", 32'(busy), 32'd1);
        abort = 1'b1; tick(); abort = 1'b0;
        loop_mode = 1'b0;

        // Pause during PACE with div=5
        do_reset();
        div = 16'd5; sif.out_ready = 1'b1;
        start_pulse();
        wait_valid_idx(0, 20, ok);
        chk("pause_first_valid", 32'(ok), 32'd1);
        v0 = cyc;
        tick();
        tick();
        en = 1'b0; seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (sif.out_valid) seen = 1'b1;
        end
        chk("pause_no_valid", 32'(seen), 32'd0);
        en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (sif.out_valid) break;
        end
        chk("pause_gap", 32'(cyc - v0), 32'd17);
        chk("pause_char", 32'(sif.out_data), 32'h61);
        chk("pause_idx", 32'(index), 32'd1);
        abort = 1'b1; tick(); abort = 1'b0;

        // Abort at index 20, then reset at index 30 on a second run
        do_reset();
        div = '0; sif.out_ready = 1'b1;
        start_pulse();
        wait_valid_idx(20, 100, ok);
        chk("abort_reach_idx20", 32'(ok), 32'd1);
        exp_cs = 8'h00;
        if (CS_ON) for (int i = 0; i < 20; i++) exp_cs = exp_cs + ch(i);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", 32'(sif.out_valid), 32'd0);
        chk("abort_data", 32'(sif.out_data), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_idx", 32'(index), 32'd0);
        chk("abort_checksum_hold", 32'(checksum), 32'(exp_cs));
        start_pulse();
        wait_valid_idx(30, 100, ok);
        chk("rst_reach_idx30", 32'(ok), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_valid", 32'(sif.out_valid), 32'd0);
        chk("midrst_data", 32'(sif.out_data), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_idx", 32'(index), 32'd0);
        chk("midrst_checksum", 32'(checksum), 32'd0);
        start_pulse();
        tick();
        chk("restart_valid", 32'(sif.out_valid), 32'd1);
        chk("restart_char", 32'(sif.out_data), 32'h54);
        chk("restart_idx", 32'(index), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
